// File: rtl/fpu_sequencer.sv
// Issue stage for the Q15 fixed-point unit: request FIFO, divide handshake and in-order writeback.
// Define FPU_SEQ_FLAGS_EN to add the registered res_nan/res_inf result flags.
module fpu_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       fpu_op,
  output logic [63:0]      fpu_a,
  output logic [63:0]      fpu_b,
  input  logic             fpu_busy,
  input  logic [63:0]      fpu_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
`ifdef FPU_SEQ_FLAGS_EN
  output logic             res_nan,
  output logic             res_inf,
`endif
  output logic             idle
);

  // state      | meaning
  // S_IDLE     | waiting for a head entry and writeback space
  // S_EXEC     | single-cycle op on the unit, result captured at the edge
  // S_DIV_LAUNCH | divide driven, waiting for the divider to be free
  // S_DIV_WAIT | divide in flight, captured when busy falls
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV_LAUNCH, S_DIV_WAIT} state_e;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] OP_DIV = 4'b0011;

  logic [3:0]       op_mem_q  [DEPTH];
  logic [63:0]      a_mem_q   [DEPTH];
  logic [63:0]      b_mem_q   [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;

  logic             res_valid_q, res_valid_d;
  logic [63:0]      res_data_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_err_q;

  logic             push, pop, load, load_err;
  logic [63:0]      load_data;
  logic             empty, full, can_start, head_unmapped;
  logic [3:0]       head_op;
  logic [63:0]      head_a, head_b;
  logic [TAG_W-1:0] head_tag;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign req_ready = !full;
  assign push      = req_valid && !full;

  assign head_op       = op_mem_q[rd_ptr_q];
  assign head_a        = a_mem_q[rd_ptr_q];
  assign head_b        = b_mem_q[rd_ptr_q];
  assign head_tag      = tag_mem_q[rd_ptr_q];
  assign head_unmapped = (head_op inside {4'b0111, 4'b1011, 4'b1110, 4'b1111});
  // Writeback space exists if the slot is empty or is being drained this cycle.
  assign can_start     = !empty && (!res_valid_q || res_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_ptr_q]  <= req_op;
      a_mem_q[wr_ptr_q]   <= req_a;
      b_mem_q[wr_ptr_q]   <= req_b;
      tag_mem_q[wr_ptr_q] <= req_tag;
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load      = 1'b0;
    load_data = '0;
    load_err  = 1'b0;
    fpu_op    = 4'b0000;
    fpu_a     = '0;
    fpu_b     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (can_start) begin
          if (head_op == OP_DIV) begin
            state_d = S_DIV_LAUNCH;
          end else if (head_unmapped) begin
            pop      = 1'b1;
            load     = 1'b1;
            load_err = 1'b1;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        fpu_op    = head_op;
        fpu_a     = head_a;
        fpu_b     = head_b;
        load      = 1'b1;
        load_data = fpu_res;
        pop       = 1'b1;
        state_d   = S_IDLE;
      end
      S_DIV_LAUNCH: begin
        fpu_op = OP_DIV;
        fpu_a  = head_a;
        fpu_b  = head_b;
        if (!fpu_busy) state_d = S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        fpu_op = OP_DIV;
        fpu_a  = head_a;
        fpu_b  = head_b;
        // The divider relaunches on this edge; the next launch simply waits it out.
        if (!fpu_busy) begin
          load      = 1'b1;
          load_data = fpu_res;
          pop       = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    res_valid_d = res_valid_q;
    if (load) res_valid_d = 1'b1;
    else if (res_valid_q && res_ready) res_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (load) begin
        res_data_q <= load_data;
        res_tag_q  <= head_tag;
        res_err_q  <= load_err;
      end
    end
  end

`ifdef FPU_SEQ_FLAGS_EN
  logic res_nan_q, res_inf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_nan_q <= 1'b0;
      res_inf_q <= 1'b0;
    end else if (load) begin
      res_nan_q <= !load_err && (load_data == 64'h8000_0000_0000_0000);
      res_inf_q <= !load_err && ((load_data == 64'h7fff_ffff_ffff_ffff) ||
                                 (load_data == 64'h8000_0000_0000_0001));
    end
  end

  assign res_nan = res_nan_q;
  assign res_inf = res_inf_q;
`endif

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_err   = res_err_q;
  assign idle      = empty && (state_q == S_IDLE) && !res_valid_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Bench for fpu_sequencer: directed vector table, multi-cycle corner sequences and randomized
// traffic against an in-order scoreboard, with a behavioural Q15 unit and multi-cycle divider.
module tb_fpu_sequencer;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 5;
  localparam int DIV_LAT = 3;

  logic             clk, rst_n;
  logic             req_valid, req_ready;
  logic [3:0]       req_op;
  logic [63:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [3:0]       fpu_op;
  logic [63:0]      fpu_a, fpu_b, fpu_res;
  logic             fpu_busy;
  logic             res_valid, res_ready, res_err, idle;
  logic [63:0]      res_data;
  logic [TAG_W-1:0] res_tag;
`ifdef FPU_SEQ_FLAGS_EN
  logic             res_nan, res_inf;
`endif

  fpu_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_busy(fpu_busy), .fpu_res(fpu_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err),
`ifdef FPU_SEQ_FLAGS_EN
    .res_nan(res_nan), .res_inf(res_inf),
`endif
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural fixed-point unit: 0000 add, 0001 sub, 0010 Q15 mul, 0011 Q15 div, others xor.
  function automatic logic [63:0] fpu_model(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic signed [127:0] sa, sb, r;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: begin r = sa * sb; return r[78:15]; end
      4'b0011: begin
        if (b == 64'd0) return '1;
        r = (sa <<< 15) / sb;
        return r[63:0];
      end
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic is_unmapped(input logic [3:0] op);
    return (op == 4'b0111) || (op == 4'b1011) || (op == 4'b1110) || (op == 4'b1111);
  endfunction

  logic fb_q;
  int   fcnt_q;
  int   launches = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_q   <= 1'b0;
      fcnt_q <= 0;
    end else if (!fb_q && fpu_op == 4'b0011) begin
      fb_q     <= 1'b1;
      fcnt_q   <= DIV_LAT;
      launches <= launches + 1;
    end else if (fb_q) begin
      fcnt_q <= fcnt_q - 1;
      if (fcnt_q == 1) fb_q <= 1'b0;
    end
  end
  assign fpu_busy = fb_q;
  // A divide result is only meaningful once the divider is no longer busy.
  always_comb fpu_res = (fpu_op == 4'b0011 && fb_q) ? 64'hBAD0_BAD0_BAD0_BAD0
                                                    : fpu_model(fpu_op, fpu_a, fpu_b);

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  typedef struct {
    logic [3:0]       op;
    logic [63:0]      a;
    logic [63:0]      b;
    logic [TAG_W-1:0] tag;
    logic [63:0]      exp_data;
    logic             exp_err;
    logic             fixed_lat;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vt[9];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   div_seen = 0;
  bit   rand_done = 0;
  int   launch_base;
  logic [3:0]  ops[13];
  logic [3:0]  r_op;
  logic [63:0] r_a, r_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (fpu_op == 4'b0011) div_seen = 1'b1;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got tag %0d data %h, required no result", res_tag,
                 res_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_data", res_data, mon_e.data);
        check("wb_tag", 64'(res_tag), 64'(mon_e.tag));
        check("wb_err", 64'(res_err), 64'(mon_e.err));
`ifdef FPU_SEQ_FLAGS_EN
        check("wb_nan", 64'(res_nan), 64'(!mon_e.err && mon_e.data == 64'h8000_0000_0000_0000));
        check("wb_inf", 64'(res_inf), 64'(!mon_e.err && (mon_e.data == 64'h7fff_ffff_ffff_ffff ||
                                                         mon_e.data == 64'h8000_0000_0000_0001)));
`endif
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic push(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [TAG_W-1:0] tag, input logic [63:0] edata, input logic eerr);
    int n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
    end else begin
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      exp_q.push_back('{edata, tag, eerr});
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic push_m(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag);
    if (is_unmapped(op)) push(op, a, b, tag, 64'd0, 1'b1);
    else push(op, a, b, tag, fpu_model(op, a, b), 1'b0);
  endtask

  task automatic wait_drain(input int limit, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || !idle) begin
      n_fail++;
      $display("FAIL %s: %0d results outstanding, idle=%0b; required 0 outstanding, idle=1",
               name, exp_q.size(), idle);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'b0000, 64'h8000,  64'h8000, 5'd3, 64'h10000, 1'b0, 1'b1};
    vt[1] = '{4'b0001, 64'h10000, 64'h4000, 5'd4, 64'hC000,  1'b0, 1'b1};
    vt[2] = '{4'b0010, 64'h10000, 64'h8000, 5'd5, 64'h10000, 1'b0, 1'b1};
    vt[3] = '{4'b0011, 64'h18000, 64'hC000, 5'd6, 64'h10000, 1'b0, 1'b0};
    vt[4] = '{4'b1111, 64'h1234,  64'h5678, 5'd7, 64'h0,     1'b1, 1'b0};
    vt[5] = '{4'b0111, 64'h1,     64'h2,    5'd8, 64'h0,     1'b1, 1'b0};
    vt[6] = '{4'b1011, 64'h3,     64'h4,    5'd9, 64'h0,     1'b1, 1'b0};
    vt[7] = '{4'b1110, 64'h5,     64'h6,    5'd10, 64'h0,    1'b1, 1'b0};
    vt[8] = '{4'b0100, 64'hF0F0,  64'h0FF0, 5'd11, 64'hFF00, 1'b0, 1'b1};
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd7, 4'd11, 4'd14, 4'd15};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_fpu_op", 64'(fpu_op), 64'd0);
    check("rst_fpu_a", fpu_a, 64'd0);
    check("rst_fpu_b", fpu_b, 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_tag", 64'(res_tag), 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      div_seen = 1'b0;
      push(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp_data, vt[i].exp_err);
      if (vt[i].fixed_lat) begin
        @(negedge clk);
        @(negedge clk);
        check("lat_not_yet", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(res_valid), 64'd1);
        @(posedge clk); #1;
      end
      wait_drain(100, "vec_drain");
      if (vt[i].op != 4'b0011) check("no_div_launch", 64'(div_seen), 64'd0);
    end

    // Divide followed by an add: the add must come back second.
    push(4'b0011, 64'h18000, 64'hC000, 5'd1, 64'h10000, 1'b0);
    push(4'b0000, 64'h8000, 64'h4000, 5'd2, 64'hC000, 1'b0);
    @(negedge clk);
    check("div_op_driven", 64'(fpu_op), 64'h3);
    @(posedge clk); #1;
    wait_drain(100, "div_add_drain");

    // Backpressure: five requests fill the writeback slot plus the FIFO.
    res_ready = 1'b0;
    push(4'b0010, 64'h10000, 64'h8000, 5'd12, 64'h10000, 1'b0);
    for (int i = 0; i < 4; i++) push_m(4'b0000, 64'(i), 64'h100, 5'(13 + i));
    repeat (3) @(negedge clk);
    check("full_req_ready", 64'(req_ready), 64'd0);
    check("full_idle", 64'(idle), 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    #1;
    check("full_no_passthru", 64'(req_ready), 64'd0);
    push_m(4'b0001, 64'h9000, 64'h1000, 5'd17);
    wait_drain(200, "backpressure_drain");

    // Back-to-back divides: the second launch must wait out the relaunch on capture.
    launch_base = launches;
    push(4'b0011, 64'd4, 64'd2, 5'd20, 64'h10000, 1'b0);
    push(4'b0011, 64'd9, 64'd3, 5'd21, 64'h18000, 1'b0);
    wait_drain(200, "b2b_div_drain");
    check("b2b_div_launches", 64'(launches - launch_base), 64'd4);

    // Reset while a divide is in flight with two requests queued behind it.
    push(4'b0011, 64'h18000, 64'hC000, 5'd22, 64'h10000, 1'b0);
    push_m(4'b0000, 64'h1, 64'h2, 5'd23);
    push_m(4'b0000, 64'h3, 64'h4, 5'd24);
    for (int n = 0; n < 50 && !fpu_busy; n++) begin
      @(posedge clk); #1;
    end
    check("mid_div_busy", 64'(fpu_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_res_valid", 64'(res_valid), 64'd0);
    check("rst_mid_idle", 64'(idle), 64'd1);
    check("rst_mid_req_ready", 64'(req_ready), 64'd1);
    check("rst_mid_fpu_op", 64'(fpu_op), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", 64'(idle), 64'd1);
    @(posedge clk); #1;

`ifdef FPU_SEQ_FLAGS_EN
    push(4'b0001, 64'd0, 64'h8000_0000_0000_0001, 5'd25, 64'h7fff_ffff_ffff_ffff, 1'b0);
    wait_drain(100, "flags_drain");
`endif

    fork
      begin
        for (int i = 0; i < 80; i++) begin
          r_op = ops[$urandom_range(0, 12)];
          r_a  = 64'($urandom_range(0, 32'h7FFFF));
          r_b  = 64'($urandom_range(1, 32'h3FFFF));
          if ($urandom_range(0, 1) == 1) r_a = -r_a;
          if ($urandom_range(0, 1) == 1) r_b = -r_b;
          push_m(r_op, r_a, r_b, 5'($urandom_range(0, 31)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
      end
    join
    wait_drain(1000, "random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
